// File: rtl/array_shift_down_if.sv
// Request, load and readback signals of the array_shift_down engine.
// The master drives requests and the load/readback ports; the slave is the engine.
interface array_shift_down_if #(
    parameter int unsigned MemoryElementWidth = 12
);
    logic                          start;
    logic [MemoryElementWidth-1:0] array;
    logic [MemoryElementWidth-1:0] pos;
    logic                          busy;
    logic                          done;
    logic                          error;
    logic [MemoryElementWidth-1:0] value;
    logic                          wrEn;
    logic [MemoryElementWidth-1:0] wrArray;
    logic [MemoryElementWidth-1:0] wrIndex;
    logic [MemoryElementWidth-1:0] wrData;
    logic [MemoryElementWidth-1:0] rdArray;
    logic [MemoryElementWidth-1:0] rdIndex;
    logic [MemoryElementWidth-1:0] rdData;
    logic [MemoryElementWidth-1:0] rdSize;

    modport master (
        output start, array, pos, wrEn, wrArray, wrIndex, wrData, rdArray, rdIndex,
        input  busy, done, error, value, rdData, rdSize
    );

    modport slave (
        input  start, array, pos, wrEn, wrArray, wrIndex, wrData, rdArray, rdIndex,
        output busy, done, error, value, rdData, rdSize
    );
endinterface

// File: rtl/array_shift_down.sv
// shiftDown engine: removes heap[NArea*array+pos], slides the tail down one slot per clock.
// Optional ARRAY_SHIFT_DOWN_CLEAR_EN zeroes the vacated slot when the removal completes.
module array_shift_down #(
    parameter int unsigned MemoryElementWidth = 12,
    parameter int unsigned NArea              = 4,
    parameter int unsigned NArrays            = 2
) (
    input logic               clock,
    input logic               reset,
    array_shift_down_if.slave bus
);
    localparam int unsigned Depth = NArea * NArrays;

    typedef logic [MemoryElementWidth-1:0] elem_t;
    typedef enum logic [1:0] {IDLE, READ, SHIFT, DONE} state_t;

    state_t      state, state_nxt;
    elem_t       heap  [Depth];
    elem_t       sizes [NArrays];
    elem_t       arr_q, pos_q, idx_q, value_q, rd_data_q, rd_size_q;
    logic        error_q;

    logic        arr_ok, pos_err, last_read, last_shift, finish_ok, wr_ok, rd_ok;
    elem_t       cur_size, heap_cur, heap_nxt;
    int unsigned base, cur_addr, wr_addr, rd_addr;

    always_comb begin
        arr_ok   = 32'(arr_q) < NArrays;
        base     = NArea * 32'(arr_q);
        cur_addr = base + 32'(idx_q);
        cur_size = '0;
        for (int unsigned k = 0; k < NArrays; k++)
            if (arr_ok && 32'(arr_q) == k) cur_size = sizes[k];
        heap_cur = '0;
        heap_nxt = '0;
        for (int unsigned k = 0; k < Depth; k++) begin
            if (k == cur_addr)         heap_cur = heap[k];
            if (k == cur_addr + 32'd1) heap_nxt = heap[k];
        end
        // size 0 always lands in pos_err, so the size-1 terms never matter on a wrap
        pos_err    = !arr_ok || (pos_q >= cur_size);
        last_read  = idx_q == cur_size - elem_t'(1);
        last_shift = idx_q + elem_t'(1) == cur_size - elem_t'(1);
        finish_ok  = (state == READ && !pos_err && last_read) || (state == SHIFT && last_shift);
        wr_ok      = bus.wrEn && (32'(bus.wrArray) < NArrays) && (32'(bus.wrIndex) < NArea);
        wr_addr    = NArea * 32'(bus.wrArray) + 32'(bus.wrIndex);
        rd_ok      = (32'(bus.rdArray) < NArrays) && (32'(bus.rdIndex) < NArea);
        rd_addr    = NArea * 32'(bus.rdArray) + 32'(bus.rdIndex);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = READ;
            READ:    state_nxt = (pos_err || last_read) ? DONE : SHIFT;
            SHIFT:   if (last_shift) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned k = 0; k < Depth; k++)   heap[k]  <= '0;
            for (int unsigned k = 0; k < NArrays; k++) sizes[k] <= '0;
            arr_q     <= '0;
            pos_q     <= '0;
            idx_q     <= '0;
            value_q   <= '0;
            error_q   <= 1'b0;
            rd_data_q <= '0;
            rd_size_q <= '0;
        end else begin
            rd_data_q <= '0;
            rd_size_q <= '0;
            for (int unsigned k = 0; k < Depth; k++)
                if (rd_ok && k == rd_addr) rd_data_q <= heap[k];
            for (int unsigned k = 0; k < NArrays; k++)
                if (32'(bus.rdArray) == k) rd_size_q <= sizes[k];

            case (state)
                IDLE: begin
                    // a write on the accept edge lands before READ looks at the heap
                    if (wr_ok) begin
                        for (int unsigned k = 0; k < Depth; k++)
                            if (k == wr_addr) heap[k] <= bus.wrData;
                        for (int unsigned k = 0; k < NArrays; k++)
                            if (32'(bus.wrArray) == k && (bus.wrIndex + elem_t'(1)) > sizes[k])
                                sizes[k] <= bus.wrIndex + elem_t'(1);
                    end
                    if (bus.start) begin
                        arr_q   <= bus.array;
                        pos_q   <= bus.pos;
                        idx_q   <= bus.pos;
                        value_q <= '0;
                        error_q <= 1'b0;
                    end
                end
                READ: begin
                    error_q <= pos_err;
                    value_q <= pos_err ? '0 : heap_cur;
                end
                SHIFT: begin
                    for (int unsigned k = 0; k < Depth; k++)
                        if (k == cur_addr) heap[k] <= heap_nxt;
                    idx_q <= idx_q + elem_t'(1);
                end
                default: ;
            endcase

            if (finish_ok) begin
                for (int unsigned k = 0; k < NArrays; k++)
                    if (32'(arr_q) == k) sizes[k] <= cur_size - elem_t'(1);
`ifdef ARRAY_SHIFT_DOWN_CLEAR_EN
                for (int unsigned k = 0; k < Depth; k++)
                    if (k == base + 32'(cur_size - elem_t'(1))) heap[k] <= '0;
`endif
            end
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.error  = error_q;
    assign bus.value  = value_q;
    assign bus.rdData = rd_data_q;
    assign bus.rdSize = rd_size_q;
endmodule

// File: tb/tb_array_shift_down.sv
// Directed bench for array_shift_down: hand-computed removals, error cases, busy rules, reset.
// Build with ARRAY_SHIFT_DOWN_CLEAR_EN to check the cleared-slot variant.
module tb_array_shift_down;
    localparam int unsigned W = 12;
`ifdef ARRAY_SHIFT_DOWN_CLEAR_EN
    localparam bit ClearEn = 1'b1;
`else
    localparam bit ClearEn = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   lat, val, err, d, s;

    array_shift_down_if #(.MemoryElementWidth(W)) bus ();

    array_shift_down #(
        .MemoryElementWidth(W),
        .NArea             (4),
        .NArrays           (2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load(input int a, input int i, input int v);
        bus.wrEn = 1'b1; bus.wrArray = W'(a); bus.wrIndex = W'(i); bus.wrData = W'(v);
        @(negedge clock);
        bus.wrEn = 1'b0;
    endtask

    task automatic rd(input int a, input int i, output int data, output int size);
        bus.rdArray = W'(a); bus.rdIndex = W'(i);
        @(negedge clock);
        data = int'(bus.rdData);
        size = int'(bus.rdSize);
    endtask

    task automatic check_slot(input string tag, input int a, input int i, input int exp);
        int dd, ss;
        rd(a, i, dd, ss);
        check(tag, dd, exp);
    endtask

    task automatic check_size(input string tag, input int a, input int exp);
        int dd, ss;
        rd(a, 0, dd, ss);
        check(tag, ss, exp);
    endtask

    // Start a removal; lat is the cycle (1 = first cycle after the accept edge) where done is seen.
    task automatic run(input int a, input int p, input bit wr, input int wa, input int wi,
                       input int wd, input bit hammer, output int latency, output int v,
                       output int e);
        latency = 0; v = -1; e = -1;
        bus.start = 1'b1; bus.array = W'(a); bus.pos = W'(p);
        if (wr) begin
            bus.wrEn = 1'b1; bus.wrArray = W'(wa); bus.wrIndex = W'(wi); bus.wrData = W'(wd);
        end
        for (int n = 1; n <= 30; n++) begin
            @(negedge clock);
            bus.start = 1'b0; bus.wrEn = 1'b0;
            if (n == 1) check("busy_c1", bus.busy, 1);
            if (bus.done) begin
                latency = n; v = int'(bus.value); e = int'(bus.error);
                break;
            end
            if (hammer && n <= 2) begin
                bus.start = 1'b1; bus.array = W'(1); bus.pos = W'(1);
                bus.wrEn = 1'b1; bus.wrArray = W'(1); bus.wrIndex = W'(3); bus.wrData = W'(55);
            end
        end
        bus.start = 1'b0; bus.wrEn = 1'b0;
        @(negedge clock);
        check("done_pulse", bus.done, 0);
        check("busy_after", bus.busy, 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.array = '0; bus.pos = '0;
        bus.wrEn = 1'b0; bus.wrArray = '0; bus.wrIndex = '0; bus.wrData = '0;
        bus.rdArray = '0; bus.rdIndex = '0;
        repeat (3) @(negedge clock);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_error", bus.error, 0);
        check("rst_value", bus.value, 0);
        check("rst_rddata", bus.rdData, 0);
        check("rst_rdsize", bus.rdSize, 0);
        reset = 1'b1;
        @(negedge clock);

        // Array 1 = [99,0,1,2]; remove index 0
        load(1, 0, 99); load(1, 1, 0); load(1, 2, 1); load(1, 3, 2);
        check_size("t1_size_before", 1, 4);
        run(1, 0, 1'b0, 0, 0, 0, 1'b0, lat, val, err);
        check("t1_latency", lat, 5);
        check("t1_value", val, 99);
        check("t1_error", err, 0);
        check_size("t1_size", 1, 3);
        check_slot("t1_slot0", 1, 0, 0);
        check_slot("t1_slot1", 1, 1, 1);
        check_slot("t1_slot2", 1, 2, 2);
        check_slot("t1_slot3", 1, 3, ClearEn ? 0 : 2);

        // Array 0 = [5,6,7]; remove the last element
        load(0, 0, 5); load(0, 1, 6); load(0, 2, 7);
        run(0, 2, 1'b0, 0, 0, 0, 1'b0, lat, val, err);
        check("t2_latency", lat, 2);
        check("t2_value", val, 7);
        check("t2_error", err, 0);
        check_size("t2_size", 0, 2);
        check_slot("t2_slot0", 0, 0, 5);
        check_slot("t2_slot1", 0, 1, 6);

        // pos == size is an error and changes nothing
        load(0, 2, 7);
        run(0, 3, 1'b0, 0, 0, 0, 1'b0, lat, val, err);
        check("t3_latency", lat, 2);
        check("t3_value", val, 0);
        check("t3_error", err, 1);
        check_size("t3_size", 0, 3);
        check_slot("t3_slot2", 0, 2, 7);

        // array number out of range
        run(2, 0, 1'b0, 0, 0, 0, 1'b0, lat, val, err);
        check("t4_latency", lat, 2);
        check("t4_error", err, 1);
        check("t4_value", val, 0);

        // start and wrEn while busy are ignored; array 1 = [0,1,2]
        run(1, 0, 1'b0, 0, 0, 0, 1'b1, lat, val, err);
        check("t5_latency", lat, 4);
        check("t5_value", val, 0);
        check("t5_error", err, 0);
        check_size("t5_size", 1, 2);
        check_slot("t5_slot0", 1, 0, 1);
        check_slot("t5_slot1", 1, 1, 2);
        check_slot("t5_slot3", 1, 3, ClearEn ? 0 : 2);

        // write and start on the same edge: array 0 becomes [42,6,7] before the removal
        run(0, 0, 1'b1, 0, 0, 42, 1'b0, lat, val, err);
        check("t6_latency", lat, 4);
        check("t6_value", val, 42);
        check_size("t6_size", 0, 2);
        check_slot("t6_slot0", 0, 0, 6);
        check_slot("t6_slot1", 0, 1, 7);

        // reset during SHIFT; array 1 = [1,2,8,9]
        load(1, 2, 8); load(1, 3, 9);
        bus.start = 1'b1; bus.array = W'(1); bus.pos = W'(0);
        @(negedge clock);
        bus.start = 1'b0;
        check("t7_busy_read", bus.busy, 1);
        @(negedge clock);
        check("t7_busy_shift", bus.busy, 1);
        reset = 1'b0;
        @(negedge clock);
        check("t7_busy_rst", bus.busy, 0);
        check("t7_done_rst", bus.done, 0);
        check("t7_value_rst", bus.value, 0);
        reset = 1'b1;
        for (int a = 0; a < 2; a++) begin
            for (int i = 0; i < 4; i++) begin
                rd(a, i, d, s);
                check($sformatf("t7_heap_%0d_%0d", a, i), d, 0);
            end
            check($sformatf("t7_size_%0d", a), s, 0);
        end

        // empty array: error, size stays 0
        run(0, 0, 1'b0, 0, 0, 0, 1'b0, lat, val, err);
        check("t8_latency", lat, 2);
        check("t8_error", err, 1);
        check("t8_value", val, 0);
        check_size("t8_size", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
